// File: rtl/br_resolve.sv
// Branch resolution consumer: tracks the oldest outstanding mispredict, flushes and redirects
// the frontend once it commits, and emits predictor updates and branch statistics.
module br_resolve #(
    parameter int unsigned ROB_DEPTH = 16,
    parameter int unsigned ROB_IDX   = $clog2(ROB_DEPTH),
    parameter int unsigned XLEN      = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               br_valid,
    input  logic [ROB_IDX-1:0] br_rob_id,
    input  logic [XLEN-1:0]    br_pc,
    input  logic               br_taken,
    input  logic [XLEN-1:0]    br_target,
    input  logic               br_miss_predict,
    input  logic [ROB_IDX-1:0] rob_head_id,
    input  logic               rob_commit_valid,
    input  logic [ROB_IDX-1:0] rob_commit_id,
    output logic               flush,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    input  logic               fe_redirect_ready,
    output logic               bp_upd_valid,
    output logic [XLEN-1:0]    bp_upd_pc,
    output logic               bp_upd_taken,
    output logic [XLEN-1:0]    bp_upd_target,
    output logic [31:0]        branch_count,
    output logic [31:0]        mispredict_count
);

    typedef enum logic [1:0] {StIdle, StPending, StFlush, StRedirect} state_e;

    state_e             state_q;
    logic [ROB_IDX-1:0] pend_id_q;
    logic [XLEN-1:0]    pend_target_q;

    logic [ROB_IDX-1:0] br_age;
    logic [ROB_IDX-1:0] pend_age;
    logic               accept_br;
    logic               commit_hit;
    logic               take_miss;

    // Modular distance from the ROB head; wraps naturally at ROB_IDX bits.
    assign br_age   = br_rob_id - rob_head_id;
    assign pend_age = pend_id_q - rob_head_id;

    // Results arriving while a flush/redirect is in flight belong to squashed ops.
    assign accept_br  = br_valid && ((state_q == StIdle) || (state_q == StPending));
    assign commit_hit = (state_q == StPending) && rob_commit_valid &&
                        (rob_commit_id == pend_id_q);
    assign take_miss  = accept_br && br_miss_predict &&
                        ((state_q == StIdle) || (br_age < pend_age));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= StIdle;
            pend_id_q        <= '0;
            pend_target_q    <= '0;
            flush            <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            bp_upd_valid     <= 1'b0;
            bp_upd_pc        <= '0;
            bp_upd_taken     <= 1'b0;
            bp_upd_target    <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            bp_upd_valid <= accept_br;
            if (accept_br) begin
                bp_upd_pc     <= br_pc;
                bp_upd_taken  <= br_taken;
                bp_upd_target <= br_target;
                branch_count  <= branch_count + 32'd1;
            end

            flush <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (take_miss) begin
                        pend_id_q     <= br_rob_id;
                        pend_target_q <= br_target;
                        state_q       <= StPending;
                    end
                end
                StPending: begin
                    // A same-cycle younger mispredict is dropped in favour of the commit.
                    if (commit_hit) begin
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= pend_target_q;
                        state_q        <= StFlush;
                    end else if (take_miss) begin
                        pend_id_q     <= br_rob_id;
                        pend_target_q <= br_target;
                    end
                end
                StFlush: begin
                    mispredict_count <= mispredict_count + 32'd1;
                    if (fe_redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state_q        <= StIdle;
                    end else begin
                        state_q <= StRedirect;
                    end
                end
                StRedirect: begin
                    if (fe_redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_br_resolve.sv
// Randomized and directed bench for br_resolve against a behavioural reference model.
module tb_br_resolve;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br_valid = 1'b0;
    logic [3:0]  br_rob_id = '0;
    logic [31:0] br_pc = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        br_miss_predict = 1'b0;
    logic [3:0]  rob_head_id = '0;
    logic        rob_commit_valid = 1'b0;
    logic [3:0]  rob_commit_id = '0;
    logic        fe_redirect_ready = 1'b0;
    logic        flush, redirect_valid, bp_upd_valid, bp_upd_taken;
    logic [31:0] redirect_pc, bp_upd_pc, bp_upd_target, branch_count, mispredict_count;

    br_resolve dut (
        .clk               (clk),
        .rst               (rst),
        .br_valid          (br_valid),
        .br_rob_id         (br_rob_id),
        .br_pc             (br_pc),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .br_miss_predict   (br_miss_predict),
        .rob_head_id       (rob_head_id),
        .rob_commit_valid  (rob_commit_valid),
        .rob_commit_id     (rob_commit_id),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .fe_redirect_ready (fe_redirect_ready),
        .bp_upd_valid      (bp_upd_valid),
        .bp_upd_pc         (bp_upd_pc),
        .bp_upd_taken      (bp_upd_taken),
        .bp_upd_target     (bp_upd_target),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: expected outputs plus the oldest unresolved mispredict, if any.
    logic        e_flush = 0, e_rv = 0, e_bpv = 0, e_bpt = 0;
    logic [31:0] e_rpc = 0, e_bppc = 0, e_bptgt = 0, e_bc = 0, e_mc = 0;
    bit          m_pend = 0;
    logic [3:0]  m_pid = 0;
    logic [31:0] m_ptgt = 0;

    function automatic int age(input logic [3:0] x, input logic [3:0] head);
        return ((int'(x) - int'(head)) + DEPTH) % DEPTH;
    endfunction

    always @(posedge clk) begin : model
        bit busy, was_flush;
        if (rst) begin
            e_flush = 0; e_rv = 0; e_rpc = 0; e_bpv = 0; e_bc = 0; e_mc = 0; m_pend = 0;
        end else begin
            busy      = e_rv;
            was_flush = e_flush;
            e_bpv     = br_valid && !busy;
            if (e_bpv) begin
                e_bppc = br_pc; e_bpt = br_taken; e_bptgt = br_target; e_bc = e_bc + 1;
            end
            if (was_flush) e_mc = e_mc + 1;
            e_flush = 0;
            if (busy) begin
                if (fe_redirect_ready) e_rv = 0;
            end else if (m_pend && rob_commit_valid && rob_commit_id == m_pid) begin
                e_flush = 1; e_rv = 1; e_rpc = m_ptgt; m_pend = 0;
            end else if (br_valid && br_miss_predict &&
                         (!m_pend || age(br_rob_id, rob_head_id) < age(m_pid, rob_head_id))) begin
                m_pend = 1; m_pid = br_rob_id; m_ptgt = br_target;
            end
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("flush", {31'b0, flush}, {31'b0, e_flush});
            chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, e_rv});
            chk("redirect_pc", redirect_pc, e_rpc);
            chk("bp_upd_valid", {31'b0, bp_upd_valid}, {31'b0, e_bpv});
            if (e_bpv) begin
                chk("bp_upd_pc", bp_upd_pc, e_bppc);
                chk("bp_upd_taken", {31'b0, bp_upd_taken}, {31'b0, e_bpt});
                chk("bp_upd_target", bp_upd_target, e_bptgt);
            end
            chk("branch_count", branch_count, e_bc);
            chk("mispredict_count", mispredict_count, e_mc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        br_valid = 0; br_miss_predict = 0; rob_commit_valid = 0;
    endtask

    task automatic br(input logic [3:0] id, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt, input logic miss);
        br_valid = 1; br_rob_id = id; br_pc = pc; br_taken = tk;
        br_target = tgt; br_miss_predict = miss;
    endtask

    task automatic commit(input logic [3:0] id);
        rob_commit_valid = 1; rob_commit_id = id;
    endtask

    initial begin
        logic [31:0] bc_hold;

        // Reset state
        rst = 1; tick(); chk_en = 1; tick(); rst = 0;
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_rv", {31'b0, redirect_valid}, 32'd0);
        chk("rst_bc", branch_count, 32'd0);

        // Correctly predicted branch -> predictor update only
        br(4'd0, 32'h1000, 1'b1, 32'h1040, 1'b0); tick(); quiet();
        chk("t1_bpv", {31'b0, bp_upd_valid}, 32'd1);
        chk("t1_pc", bp_upd_pc, 32'h1000);
        chk("t1_tgt", bp_upd_target, 32'h1040);
        chk("t1_bc", branch_count, 32'd1);
        chk("t1_flush", {31'b0, flush}, 32'd0);

        // Mispredict committed with frontend already ready
        rob_head_id = 0; br(4'd5, 32'h1100, 1'b1, 32'h2000, 1'b1); tick(); quiet();
        tick(); tick();
        commit(4'd5); fe_redirect_ready = 1; tick(); quiet();
        chk("t2_flush", {31'b0, flush}, 32'd1);
        chk("t2_rpc", redirect_pc, 32'h2000);
        tick();
        chk("t2_flush_off", {31'b0, flush}, 32'd0);
        chk("t2_rv_off", {31'b0, redirect_valid}, 32'd0);
        chk("t2_mc", mispredict_count, 32'd1);

        // Older mispredict replaces younger
        rob_head_id = 2;
        br(4'd7, 32'h1200, 1'b0, 32'h3100, 1'b1); tick();
        br(4'd4, 32'h1300, 1'b1, 32'h3000, 1'b1); tick(); quiet();
        commit(4'd7); tick();
        chk("t3_no_flush", {31'b0, flush}, 32'd0);
        commit(4'd4); tick(); quiet();
        chk("t3_flush", {31'b0, flush}, 32'd1);
        chk("t3_rpc", redirect_pc, 32'h3000);
        tick();

        // Age comparison across the wrap point
        rob_head_id = 14;
        br(4'd1, 32'h1400, 1'b1, 32'h4001, 1'b1); tick();
        br(4'd15, 32'h1500, 1'b1, 32'h4015, 1'b1); tick();
        br(4'd0, 32'h1600, 1'b1, 32'h4000, 1'b1); tick(); quiet();
        commit(4'd0); tick();
        chk("t4_no_flush0", {31'b0, flush}, 32'd0);
        commit(4'd1); tick();
        chk("t4_no_flush1", {31'b0, flush}, 32'd0);
        commit(4'd15); tick(); quiet();
        chk("t4_flush", {31'b0, flush}, 32'd1);
        chk("t4_rpc", redirect_pc, 32'h4015);
        tick();

        // Stalled frontend; squashed branch results ignored
        rob_head_id = 0; fe_redirect_ready = 0;
        br(4'd3, 32'h1700, 1'b1, 32'h5000, 1'b1); tick(); quiet();
        commit(4'd3); tick(); quiet();
        chk("t5_flush", {31'b0, flush}, 32'd1);
        bc_hold = branch_count;
        for (int i = 0; i < 4; i++) begin
            br(4'(i + 8), 32'h1800 + 32'(i), 1'b1, 32'h6000, 1'b0); tick();
            chk("t5_flush_once", {31'b0, flush}, 32'd0);
            chk("t5_rv_hold", {31'b0, redirect_valid}, 32'd1);
            chk("t5_rpc_hold", redirect_pc, 32'h5000);
            chk("t5_no_bpv", {31'b0, bp_upd_valid}, 32'd0);
        end
        quiet(); fe_redirect_ready = 1; tick();
        chk("t5_rv_off", {31'b0, redirect_valid}, 32'd0);
        chk("t5_bc", branch_count, bc_hold);

        // Reset during redirect
        fe_redirect_ready = 0;
        br(4'd6, 32'h1900, 1'b0, 32'h7000, 1'b1); tick(); quiet();
        commit(4'd6); tick(); quiet(); tick();
        chk("t6_rv_before", {31'b0, redirect_valid}, 32'd1);
        rst = 1; tick(); rst = 0;
        chk("t6_rv", {31'b0, redirect_valid}, 32'd0);
        chk("t6_bc", branch_count, 32'd0);
        chk("t6_mc", mispredict_count, 32'd0);
        commit(4'd6); tick(); quiet();
        chk("t6_no_flush", {31'b0, flush}, 32'd0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst               = ($urandom_range(0, 299) == 0);
            br_valid          = ($urandom_range(0, 1) == 1);
            br_rob_id         = 4'($urandom);
            br_pc             = $urandom;
            br_taken          = 1'($urandom);
            br_target         = $urandom;
            br_miss_predict   = ($urandom_range(0, 9) < 4);
            if ($urandom_range(0, 7) == 0) rob_head_id = 4'($urandom);
            rob_commit_valid  = ($urandom_range(0, 9) < 3);
            rob_commit_id     = (m_pend && $urandom_range(0, 1) == 1) ? m_pid : 4'($urandom);
            fe_redirect_ready = ($urandom_range(0, 9) < 4);
            tick();
        end
        rst = 0; quiet(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/br_resolve.md
Name: br_resolve

Overview:
- Consumer end of the branch CDB: receives resolved-branch results from the branch functional unit.
- Holds the oldest outstanding mispredict until that branch commits at the ROB head, then issues a one-cycle pipeline flush and a redirect to the frontend under a valid/ready handshake.
- Emits a registered predictor-update record for every resolved branch.
- Keeps branch and mispredict statistics counters.

Parameters:
ROB_DEPTH, 16, number of ROB entries; power of two.
ROB_IDX, $clog2(ROB_DEPTH), ROB id width.
XLEN, 32, PC width.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
br_valid  input  1  branch result valid this cycle
br_rob_id  input  ROB_IDX  ROB id of resolved branch
br_pc  input  XLEN  PC of branch
br_taken  input  1  actual direction
br_target  input  XLEN  actual next PC (target if taken, pc+4 otherwise)
br_miss_predict  input  1  prediction was wrong
rob_head_id  input  ROB_IDX  current ROB head id, for age compare
rob_commit_valid  input  1  head entry commits this cycle
rob_commit_id  input  ROB_IDX  id committing
flush  output  1  one-cycle backend/frontend squash pulse
redirect_valid  output  1  redirect request to frontend
redirect_pc  output  XLEN  fetch restart PC
fe_redirect_ready  input  1  frontend accepts redirect
bp_upd_valid  output  1  predictor update valid
bp_upd_pc  output  XLEN  update PC
bp_upd_taken  output  1  update direction
bp_upd_target  output  XLEN  update target
branch_count  output  32  resolved branches since reset
mispredict_count  output  32  committed mispredicts since reset

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; pending registers cleared. Reset mid-operation, including during FLUSH or REDIRECT, aborts immediately with no further pulses.
- States:
  - IDLE: no pending mispredict.
  - PENDING: holds pend_id and pend_target.
  - FLUSH: single cycle.
  - REDIRECT: waiting on the frontend.
- Age: age(x) = (x - rob_head_id) mod ROB_DEPTH, unsigned ROB_IDX-bit subtraction; smaller is older.
- IDLE:
  - br_valid && br_miss_predict → capture id and target, go to PENDING next cycle.
- PENDING:
  - br_valid && br_miss_predict && age(br_rob_id) < age(pend_id) → replace pend_id/pend_target.
  - Equal or younger → ignored.
- Commit:
  - In PENDING, rob_commit_valid && rob_commit_id == pend_id → FLUSH. Compare only against the registered pend_id.
  - Commit takes priority over a same-cycle capture or replace; the same-cycle input is dropped because it is necessarily younger.
- FLUSH:
  - flush=1 for exactly this cycle; redirect_valid=1 and redirect_pc=pend_target from this cycle on.
  - mispredict_count += 1.
  - Next state REDIRECT, or IDLE if fe_redirect_ready is already 1 in this cycle.
- REDIRECT:
  - redirect_valid and redirect_pc held stable until the fe_redirect_ready handshake.
  - IDLE on the cycle after the handshake.
- br_valid arriving in FLUSH or REDIRECT is ignored entirely: no capture, no bp update, no branch_count increment. It is a squashed younger op.
- Predictor update:
  - Registered with 1-cycle latency: br_valid in cycle N → bp_upd_* valid in cycle N+1 with N's fields.
  - Applies in IDLE and PENDING only; otherwise bp_upd_valid=0.
  - branch_count increments under the same condition.
- Counters wrap modulo 2^32.
- redirect_pc is registered; flush is a registered output, not combinational from inputs.

Test Plan:
- Reset, then br_valid with miss_predict=0, pc=0x1000, taken=1, target=0x1040 → next cycle bp_upd_valid=1 with pc=0x1000, taken=1, target=0x1040; branch_count=1; no flush.
- head=0; mispredict id=5, target=0x2000; commit id=5 three cycles later with fe_redirect_ready=1 → flush high exactly 1 cycle; redirect_pc=0x2000; mispredict_count=1; back to IDLE.
- head=2; mispredict id=7 then id=4, target 0x3000 → id 4 replaces 7. Commit id=7 → no flush. Commit id=4 → flush, redirect_pc=0x3000.
- head=14, depth 16: pending id=1 (age 3), then mispredict id=15 (age 1) → replace; then mispredict id=0 (age 2) → ignored. Checks wrap-around.
- FLUSH with fe_redirect_ready=0 for 4 cycles → redirect_valid and redirect_pc stable for 4 cycles, flush pulsed only once; br_valid injected meanwhile → no bp_upd, branch_count unchanged.
- Assert rst during REDIRECT → next cycle redirect_valid=0, counters 0, IDLE; a subsequent commit of the old id → no flush.
